// File: rtl/fdct4x4_stream_pkg.sv
// Shared constants for the 4x4 forward integer transform: widths, per-pass growth
// and the sign pattern of the 4-point kernel.
package fdct4x4_stream_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int GROWTH    = 2;

  typedef enum logic [1:0] {
    K_NOP = 2'b00,
    K_ADD = 2'b01,
    K_SUB = 2'b11
  } ksign_e;

  // Row i of the table is coefficient Ci; column j says how sample xj contributes.
  localparam ksign_e KSIGN [4][4] = '{
    '{K_ADD, K_ADD, K_ADD, K_ADD},
    '{K_ADD, K_NOP, K_NOP, K_SUB},
    '{K_ADD, K_SUB, K_SUB, K_ADD},
    '{K_NOP, K_SUB, K_ADD, K_NOP}
  };

  function automatic int out_width(input int w);
    return w + 2 * GROWTH;
  endfunction

endpackage

// File: rtl/fdct4x4_stream_if.sv
// Row-in / column-out stream bundle of the 4x4 transform; master is the
// block-fetch/consumer side, slave is the transform.
interface fdct4x4_stream_if
  import fdct4x4_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int OWIDTH = out_width(WIDTH);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [WIDTH-1:0]  in_x0;
  logic signed [WIDTH-1:0]  in_x1;
  logic signed [WIDTH-1:0]  in_x2;
  logic signed [WIDTH-1:0]  in_x3;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OWIDTH-1:0] out_y0;
  logic signed [OWIDTH-1:0] out_y1;
  logic signed [OWIDTH-1:0] out_y2;
  logic signed [OWIDTH-1:0] out_y3;
  logic                     out_last;

  modport master (
    output in_valid, in_x0, in_x1, in_x2, in_x3, out_ready,
    input  in_ready, out_valid, out_y0, out_y1, out_y2, out_y3, out_last
  );

  modport slave (
    input  in_valid, in_x0, in_x1, in_x2, in_x3, out_ready,
    output in_ready, out_valid, out_y0, out_y1, out_y2, out_y3, out_last
  );

endinterface

// File: rtl/fdct4x4_stream_fdct4.sv
// Combinational 4-point forward kernel; output is two bits wider than the input
// so no sum can overflow.
module fdct4x4_stream_fdct4
  import fdct4x4_stream_pkg::*;
#(
  parameter int IW = DEF_WIDTH
) (
  input  logic signed [IW-1:0]        x [4],
  output logic signed [IW+GROWTH-1:0] y [4]
);
  localparam int OW = IW + GROWTH;

  // Each coefficient is a signed sum of the samples, widened before summing.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      y[i] = '0;
      for (int j = 0; j < 4; j++) begin
        case (KSIGN[i][j])
          K_ADD:   y[i] = y[i] + OW'(x[j]);
          K_SUB:   y[i] = y[i] - OW'(x[j]);
          default: y[i] = y[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/fdct4x4_stream.sv
// Streaming 4x4 forward transform: row pass into a ping-pong transpose buffer,
// column pass read combinationally out of the full bank one column per beat.
module fdct4x4_stream
  import fdct4x4_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  fdct4x4_stream_if.slave  io
);
  localparam int RWIDTH = WIDTH + GROWTH;
  localparam int OWIDTH = RWIDTH + GROWTH;

  logic signed [WIDTH-1:0]  row_x_s [4];
  logic signed [RWIDTH-1:0] row_r_s [4];
  logic signed [RWIDTH-1:0] col_x_s [4];
  logic signed [OWIDTH-1:0] col_y_s [4];
  logic signed [RWIDTH-1:0] bank_r  [2][4][4];

  logic [1:0] full_r;
  logic [1:0] full_nxt_s;
  logic       wr_sel_r;
  logic       rd_sel_r;
  logic [1:0] wr_row_r;
  logic [1:0] rd_col_r;
  logic       in_fire_s;
  logic       out_fire_s;
  logic       fill_done_s;
  logic       drain_done_s;

  // Handshake decode; fill and drain always target different banks, so both
  // flag updates may land in the same cycle.
  always_comb begin
    in_fire_s    = io.in_valid & ~full_r[wr_sel_r];
    out_fire_s   = full_r[rd_sel_r] & io.out_ready;
    fill_done_s  = in_fire_s & (wr_row_r == 2'd3);
    drain_done_s = out_fire_s & (rd_col_r == 2'd3);
    full_nxt_s   = full_r;
    for (int b = 0; b < 2; b++) begin
      full_nxt_s[b] = (full_r[b] | (fill_done_s & (wr_sel_r == 1'(b))))
                    & ~(drain_done_s & (rd_sel_r == 1'(b)));
    end
  end

  // Kernel operand routing: incoming row, and column rd_col of the read bank.
  always_comb begin
    row_x_s[0] = io.in_x0;
    row_x_s[1] = io.in_x1;
    row_x_s[2] = io.in_x2;
    row_x_s[3] = io.in_x3;
    for (int r = 0; r < 4; r++) begin
      col_x_s[r] = bank_r[rd_sel_r][r][rd_col_r];
    end
  end

  fdct4x4_stream_fdct4 #(.IW(WIDTH))  u_row_pass (.x(row_x_s), .y(row_r_s));
  fdct4x4_stream_fdct4 #(.IW(RWIDTH)) u_col_pass (.x(col_x_s), .y(col_y_s));

  assign io.in_ready  = ~full_r[wr_sel_r];
  assign io.out_valid = full_r[rd_sel_r];
  assign io.out_last  = full_r[rd_sel_r] & (rd_col_r == 2'd3);
  assign io.out_y0    = col_y_s[0];
  assign io.out_y1    = col_y_s[1];
  assign io.out_y2    = col_y_s[2];
  assign io.out_y3    = col_y_s[3];

  // Bank flags, ping-pong pointers and row/column counters.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      full_r   <= 2'b00;
      wr_sel_r <= 1'b0;
      rd_sel_r <= 1'b0;
      wr_row_r <= 2'd0;
      rd_col_r <= 2'd0;
    end else begin
      full_r <= full_nxt_s;
      if (fill_done_s) begin
        wr_sel_r <= ~wr_sel_r;
        wr_row_r <= 2'd0;
      end else if (in_fire_s) begin
        wr_row_r <= wr_row_r + 2'd1;
      end
      if (drain_done_s) begin
        rd_sel_r <= ~rd_sel_r;
        rd_col_r <= 2'd0;
      end else if (out_fire_s) begin
        rd_col_r <= rd_col_r + 2'd1;
      end
    end
  end

  // Transpose storage; cleared on reset so no residue survives an abort.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            bank_r[b][r][c] <= '0;
          end
        end
      end
    end else if (in_fire_s) begin
      for (int c = 0; c < 4; c++) begin
        bank_r[wr_sel_r][wr_row_r][c] <= row_r_s[c];
      end
    end
  end

endmodule

// File: tb/tb_fdct4x4_stream.sv
// Scoreboard bench for fdct4x4_stream: matrix reference model, occupancy model
// of the handshake, stall-stability and exact 2-D inverse checks.
module tb_fdct4x4_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;

  int cm [4][4] = '{'{1, 1, 1, 1}, '{1, 0, 0, -1}, '{1, -1, -1, 1}, '{0, -1, 1, 0}};
  int dn [4] = '{4, 2, 4, 2};

  int xq [$];
  int yq [$];

  fdct4x4_stream_if #(.WIDTH(8)) io ();
  fdct4x4_stream #(.WIDTH(8)) dut (.ap_clk(clk), .ap_rst(rst), .io(io));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Y = C * X * C^T with plain integer matrix products.
  task automatic model(input int x [4][4], output int y [4][4]);
    int r [4][4];
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        r[i][k] = 0;
        for (int m = 0; m < 4; m++) r[i][k] += cm[k][m] * x[i][m];
      end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        y[i][k] = 0;
        for (int j = 0; j < 4; j++) y[i][k] += cm[i][j] * r[j][k];
      end
  endtask

  task automatic send_rows(input int b [4][4], input int n);
    bit ok;
    for (int r = 0; r < n; r++) begin
      io.in_valid = 1'b1;
      io.in_x0 = 8'(b[r][0]);
      io.in_x1 = 8'(b[r][1]);
      io.in_x2 = 8'(b[r][2]);
      io.in_x3 = 8'(b[r][3]);
      ok = 1'b0;
      for (int t = 0; t < 300 && !ok; t++) begin
        @(negedge clk);
        ok = io.in_ready;
        @(posedge clk);
        #1;
      end
      chk("row_accept_timeout", int'(ok), 1);
    end
    io.in_valid = 1'b0;
  endtask

  task automatic send_block(input int b [4][4]);
    int y [4][4];
    send_rows(b, 4);
    model(b, y);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        xq.push_back(b[i][k]);
        yq.push_back(y[i][k]);
      end
  endtask

  task automatic fill_const(output int b [4][4], input int v);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) b[i][k] = v;
  endtask

  task automatic fill_rand(output int b [4][4]);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) b[i][k] = int'($urandom_range(255)) - 128;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, int'(io.in_ready), 1);
    chk({tag, "_out_valid"}, int'(io.out_valid), 0);
    chk({tag, "_out_last"}, int'(io.out_last), 0);
    chk({tag, "_y0"}, int'(io.out_y0), 0);
    chk({tag, "_y1"}, int'(io.out_y1), 0);
    chk({tag, "_y2"}, int'(io.out_y2), 0);
    chk({tag, "_y3"}, int'(io.out_y3), 0);
  endtask

  task automatic apply_reset(input string tag);
    io.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(posedge clk);
      #1;
      done = (xq.size() == 0) && !io.out_valid;
    end
    chk("drain_timeout", int'(done), 1);
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = random 50%, else stalled.
  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       io.out_ready = 1'b1;
        1:       io.out_ready = 1'($urandom_range(1));
        default: io.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor state.
  int  rows_in = 0;
  int  cols_out = 0;
  int  mon_col = 0;
  int  occ;
  bit  have_cur = 1'b0;
  bit  stall = 1'b0;
  int  prev_y [4];
  int  prev_last;
  int  ys [4];
  int  cur_x [4][4];
  int  cur_y [4][4];
  int  got [4][4];
  int  z [4][4];
  int  acc;

  always @(negedge clk) begin
    if (rst) begin
      rows_in = 0;
      cols_out = 0;
      mon_col = 0;
      have_cur = 1'b0;
      stall = 1'b0;
      xq.delete();
      yq.delete();
    end else begin
      ys[0] = int'(io.out_y0);
      ys[1] = int'(io.out_y1);
      ys[2] = int'(io.out_y2);
      ys[3] = int'(io.out_y3);
      occ = rows_in / 4 - cols_out / 4;
      chk("in_ready_occupancy", int'(io.in_ready), int'(occ < 2));
      chk("out_valid_occupancy", int'(io.out_valid), int'(occ > 0));
      if (stall) begin
        chk("stall_valid", int'(io.out_valid), 1);
        chk("stall_last", int'(io.out_last), prev_last);
        for (int i = 0; i < 4; i++) chk("stall_y", ys[i], prev_y[i]);
      end
      if (io.out_valid) chk("out_last", int'(io.out_last), int'(mon_col == 3));
      if (io.out_valid && io.out_ready) begin
        if (mon_col == 0) begin
          have_cur = (xq.size() >= 16);
          if (!have_cur) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got an output column, expected none");
          end else begin
            for (int i = 0; i < 4; i++)
              for (int k = 0; k < 4; k++) begin
                cur_x[i][k] = xq.pop_front();
                cur_y[i][k] = yq.pop_front();
              end
          end
        end
        if (have_cur) begin
          for (int i = 0; i < 4; i++) begin
            chk("coef", ys[i], cur_y[i][mon_col]);
            got[i][mon_col] = ys[i];
          end
        end
        if (mon_col == 3) begin
          if (have_cur) begin
            // X = C^T D^-1 Y D^-1 C, scaled by 16 to stay in integers.
            for (int i = 0; i < 4; i++)
              for (int k = 0; k < 4; k++) z[i][k] = got[i][k] * (16 / (dn[i] * dn[k]));
            for (int j = 0; j < 4; j++)
              for (int m = 0; m < 4; m++) begin
                acc = 0;
                for (int i = 0; i < 4; i++)
                  for (int k = 0; k < 4; k++) acc += cm[i][j] * z[i][k] * cm[k][m];
                chk("inverse", acc, 16 * cur_x[j][m]);
              end
          end
          mon_col = 0;
        end else begin
          mon_col++;
        end
        cols_out++;
      end
      stall = io.out_valid && !io.out_ready;
      prev_y = ys;
      prev_last = int'(io.out_last);
      if (io.in_valid && io.in_ready) rows_in++;
    end
  end

  initial begin
    int b [4][4];
    io.in_valid = 1'b0;
    io.in_x0 = 8'sd0;
    io.in_x1 = 8'sd0;
    io.in_x2 = 8'sd0;
    io.in_x3 = 8'sd0;
    #2;
    check_reset_values("por");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed blocks streamed back to back with downstream always ready.
    rdy_mode = 0;
    fill_const(b, 10);
    send_block(b);
    fill_const(b, 0);
    b[0][0] = 1;
    send_block(b);
    fill_const(b, -128);
    send_block(b);
    fill_const(b, 127);
    send_block(b);
    for (int n = 0; n < 3; n++) begin
      fill_rand(b);
      send_block(b);
    end
    wait_drain();

    // Random blocks against a random downstream.
    rdy_mode = 1;
    for (int n = 0; n < 8; n++) begin
      fill_rand(b);
      send_block(b);
    end
    wait_drain();

    // Full stall: both banks fill and input backs up before draining.
    rdy_mode = 2;
    for (int n = 0; n < 2; n++) begin
      fill_rand(b);
      send_block(b);
    end
    repeat (4) @(posedge clk);
    #1;
    rdy_mode = 1;
    fill_rand(b);
    send_block(b);
    wait_drain();

    // Reset after two rows of a block.
    rdy_mode = 0;
    fill_rand(b);
    send_rows(b, 2);
    apply_reset("rst_mid_fill");
    fill_rand(b);
    send_block(b);
    wait_drain();

    // Reset in the middle of draining.
    fill_rand(b);
    send_block(b);
    repeat (2) @(posedge clk);
    #1;
    apply_reset("rst_mid_drain");
    fill_const(b, 10);
    send_block(b);
    wait_drain();

    chk("scoreboard_empty", xq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
